// File: rtl/seq_divider32by16_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Default widths match the 32-bit product / 16-bit operand datapath.
package seq_divider32by16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int DIV_WN = 32;
  localparam int DIV_WD = 16;
  localparam int DIV_CW = $clog2(DIV_WN);

  // Quotient reported for a zero divisor
  localparam logic [DIV_WN-1:0] DIV_DBZ_Q = '1;

endpackage

// File: rtl/seq_divider32by16_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and report the quotient bit.
module div_step #(
  parameter int WIDTH_D = 16
) (
  input  logic [WIDTH_D:0]   r,
  input  logic               bit_in,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D:0]   r_next,
  output logic               q_bit
);

  // r stays below divisor, so its top bit is always zero; carrying it into the
  // wider trial value keeps the compare exact without special-casing it.
  logic [WIDTH_D+1:0] t_wide;

  assign t_wide = {r, bit_in};
  assign q_bit  = (t_wide >= {2'b00, divisor});
  assign r_next = q_bit ? (WIDTH_D+1)'(t_wide - {2'b00, divisor})
                        : (WIDTH_D+1)'(t_wide);

endmodule

// File: rtl/seq_divider32by16.sv
// Multi-cycle unsigned radix-2 restoring divider with valid/ready handshakes,
// resolving one quotient bit per clock; a zero divisor completes immediately.
module seq_divider32by16
  import seq_divider32by16_pkg::*;
#(
  parameter int WIDTH_N = DIV_WN,
  parameter int WIDTH_D = DIV_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid holds until taken.
  localparam int CW = $clog2(WIDTH_N);
  localparam logic [WIDTH_N-1:0] DBZ_Q = {WIDTH_N{DIV_DBZ_Q[0]}};

  div_state_e         state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] q_reg;
  logic [WIDTH_D:0]   r_reg;
  logic [WIDTH_D:0]   r_step;
  logic [WIDTH_D-1:0] d_reg;
  logic               q_bit;
  logic               dbz_reg;
  logic               accept;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign quotient    = q_reg;
  assign remainder   = r_reg[WIDTH_D-1:0];
  assign div_by_zero = dbz_reg;

  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .r      (r_reg),
    .bit_in (q_reg[WIDTH_N-1]),
    .divisor(d_reg),
    .r_next (r_step),
    .q_bit  (q_bit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            if (divisor == '0) begin
              q_reg   <= DBZ_Q;
              r_reg   <= {1'b0, dividend[WIDTH_D-1:0]};
              dbz_reg <= 1'b1;
            end else begin
              d_reg   <= divisor;
              q_reg   <= dividend;
              r_reg   <= '0;
              cnt     <= CW'(WIDTH_N - 1);
              dbz_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          // Dividend bits leave at the top while quotient bits enter at the bottom
          q_reg <= {q_reg[WIDTH_N-2:0], q_bit};
          r_reg <= r_step;
          cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32by16.sv
// Self-checking bench for seq_divider32by16: vector table, hand-written
// corner sequences and randomized operations checked against an arithmetic model.
module tb_seq_divider32by16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  // Expected results as {div_by_zero, quotient, remainder}
  logic [48:0] exp_q[$];

  seq_divider32by16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [48:0] model(input logic [31:0] n, input logic [15:0] d);
    logic [31:0] dd;
    dd = {16'd0, d};
    if (d == 16'd0) return {1'b1, 32'hFFFF_FFFF, n[15:0]};
    return {1'b0, n / dd, 16'(n % dd)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] n, input logic [15:0] d, input int hold,
                        input int exp_lat, input logic [48:0] e, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    dividend  = n;
    divisor   = d;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    wait_result(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, 64'({div_by_zero, quotient, remainder}), 64'(e));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold"}, 64'({out_valid, in_ready, div_by_zero, quotient, remainder}),
            64'({1'b1, 1'b0, e}));
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_release"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] n;
    logic [15:0] d;
    int          hold;
    int          lat;
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    bit seen;
    logic [48:0] e;
    logic [31:0] rn;
    logic [15:0] rd;

    vecs[0] = '{32'd100,        16'd7,      0, 32, 32'd14,          16'd2,      1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  16'hFFFF,   0, 32, 32'h0001_0001,   16'd0,      1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  16'd1,      0, 32, 32'hFFFF_FFFF,   16'd0,      1'b0};
    vecs[3] = '{32'h1234_5678,  16'd0,      0, 0,  32'hFFFF_FFFF,   16'h5678,   1'b1};
    vecs[4] = '{32'd1000,       16'd33,     5, 32, 32'd30,          16'd10,     1'b0};
    vecs[5] = '{32'd0,          16'd5,      0, 32, 32'd0,           16'd0,      1'b0};
    vecs[6] = '{32'd5,          16'd10,     0, 32, 32'd0,           16'd5,      1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    #12;
    chk("reset_state", 64'({in_ready, out_valid, div_by_zero, quotient, remainder}),
        64'({1'b1, 1'b0, 1'b0, 32'd0, 16'd0}));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].n, vecs[i].d, vecs[i].hold, vecs[i].lat,
             {vecs[i].z, vecs[i].q, vecs[i].r}, $sformatf("vec%0d", i));

    // Reset in the middle of a calculation drops the operation entirely
    @(negedge clk);
    in_valid = 1'b1; dividend = 32'd50000; divisor = 16'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_state", 64'({in_ready, out_valid, div_by_zero, quotient, remainder}),
        64'({1'b1, 1'b0, 1'b0, 32'd0, 16'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_stale", 64'(seen), 64'd0);
    run_op(32'd9, 16'd4, 0, 32, {1'b0, 32'd2, 16'd1}, "after_abort");

    // Back-to-back with in_valid held high; operand change during CALC is ignored
    @(negedge clk);
    in_valid = 1'b1; dividend = 32'd6; divisor = 16'd3; out_ready = 1'b1;
    exp_q.push_back(model(32'd6, 16'd3));
    @(posedge clk); #1;
    dividend = 32'd7; divisor = 16'd2;
    exp_q.push_back(model(32'd7, 16'd2));
    wait_result(lat);
    chk("b2b_first_latency", 64'(lat), 64'd32);
    e = exp_q.pop_front();
    chk("b2b_first_result", 64'({div_by_zero, quotient, remainder}), 64'(e));
    chk("b2b_first_const", 64'({quotient, remainder}), 64'({32'd2, 16'd0}));
    @(posedge clk); #1;
    chk("b2b_idle_gap", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("b2b_second_accept", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_result(lat);
    chk("b2b_second_latency", 64'(lat), 64'd32);
    e = exp_q.pop_front();
    chk("b2b_second_result", 64'({div_by_zero, quotient, remainder}), 64'(e));
    chk("b2b_second_const", 64'({quotient, remainder}), 64'({32'd3, 16'd1}));
    @(posedge clk); #1;

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       rd = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'd1;
        1:       rd = 16'($urandom_range(1, 15));
        default: rd = 16'($urandom);
      endcase
      rn = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      run_op(rn, rd, $urandom_range(0, 2), (rd == 16'd0) ? 0 : 32, model(rn, rd),
             $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
